ram_arbiter: RTL and testbench

Two-port arbiter that shares the single-port `ram` block between the instruction-fetch port (A, read-only) and the load/store port (B, read/write) of the core. It serialises accesses with a four-state FSM and round-robin priority, and drives the RAM address, write-enable and write-data from registered command state. It returns read data and a one-cycle acknowledge to the winning port. It sits between the core's fetch and memory stages and the `ram` instance.

---
 rtl/ram_arbiter.sv | 153 +++++++++++++++
 tb/tb_ram_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between the instruction-fetch port (A,
// read-only) and the load/store port (B, read/write). It performs one access at a
// time through IDLE -> ISSUE -> WAIT -> DONE. Round-robin priority applies when
// both ports request in the same IDLE cycle.
module ram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,

    // Port A: instruction fetch, read-only
    input  logic                  i_a_req,
    input  logic [ADDR_WIDTH-1:0] i_a_addr,
    output logic                  o_a_ack,
    output logic [DATA_WIDTH-1:0] o_a_rdata,

    // Port B: load/store
    input  logic                  i_b_req,
    input  logic                  i_b_we,
    input  logic [ADDR_WIDTH-1:0] i_b_addr,
    input  logic [DATA_WIDTH-1:0] i_b_wdata,
    output logic                  o_b_ack,
    output logic [DATA_WIDTH-1:0] o_b_rdata,

    // RAM side
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic                  o_ram_we,
    output logic [DATA_WIDTH-1:0] o_ram_wdata,
    input  logic [DATA_WIDTH-1:0] i_ram_rdata,

    output logic                  o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

    state_t state;
    state_t state_nxt;

    grant_t last_grant;   // port served by the most recently completed access
    grant_t arb_grant;    // winner if the FSM leaves IDLE this cycle
    grant_t cmd_grant;    // port owning the access in flight
    logic   cmd_we;       // access in flight is a write
    logic   any_req;
    logic   start;        // an access is accepted at the end of this cycle

    // Round-robin arbitration between the two requesters, evaluated every cycle
    // but only acted on in IDLE.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        arb_grant = GRANT_A;
        any_req   = i_a_req | i_b_req;
        if (i_a_req && i_b_req) begin
            arb_grant = (last_grant == GRANT_B) ? GRANT_A : GRANT_B;
        end else if (i_b_req) begin
            arb_grant = GRANT_B;
        end
    end

    assign start = (state == ST_IDLE) && any_req;

    // Next-state logic: only IDLE waits on requests, the access phases are fixed.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (any_req) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Command registers: capture the winner's address, direction and data on the
    // IDLE -> ISSUE edge. The RAM address and write-data outputs are these
    // registers, so they hold their value for the rest of the access and
    // beyond. A port-A access leaves the write-data register unchanged.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cmd_grant   <= GRANT_A;
            cmd_we      <= 1'b0;
            o_ram_addr  <= '0;
            o_ram_wdata <= '0;
        end else if (start) begin
            cmd_grant <= arb_grant;
            if (arb_grant == GRANT_B) begin
                cmd_we      <= i_b_we;
                o_ram_addr  <= i_b_addr;
                o_ram_wdata <= i_b_wdata;
            end else begin
                cmd_we      <= 1'b0;
                o_ram_addr  <= i_a_addr;
            end
        end
    end

    // Read-data return: the RAM output is valid during WAIT and is captured on the
    // WAIT -> DONE edge into the granted port's holding register. Writes leave both
    // registers untouched.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_a_rdata <= '0;
            o_b_rdata <= '0;
        end else if (state == ST_WAIT && !cmd_we) begin
            if (cmd_grant == GRANT_A) begin
                o_a_rdata <= i_ram_rdata;
            end else begin
                o_b_rdata <= i_ram_rdata;
            end
        end
    end

    // Round-robin history: updated when the access retires (DONE -> IDLE).
    // It resets to B so that A wins the first contention.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            last_grant <= GRANT_B;
        end else if (state == ST_DONE) begin
            last_grant <= cmd_grant;
        end
    end

    // Outputs decoded from registered state only; no path from any request input.
    // The write strobe is high for the single ISSUE cycle of a B write. The RAM
    // samples it on the same edge that may also apply reset, so a write that has
    // reached the end of ISSUE still commits.
    assign o_ram_we = (state == ST_ISSUE) && cmd_we;
    assign o_a_ack  = (state == ST_DONE) && (cmd_grant == GRANT_A);
    assign o_b_ack  = (state == ST_DONE) && (cmd_grant == GRANT_B);
    assign o_busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter. A behavioural single-port RAM sits on the RAM side.
// A transaction-level model predicts every output on every cycle: it counts
// cycles since a request was accepted and keeps a mirror of the memory
// contents. Directed steps are followed by a randomized phase.
module tb_ram_arbiter;

    localparam int DW = 32;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_req;
    logic [AW-1:0] a_addr;
    logic          a_ack;
    logic [DW-1:0] a_rdata;
    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_ack;
    logic [DW-1:0] b_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_a_req     (a_req),
        .i_a_addr    (a_addr),
        .o_a_ack     (a_ack),
        .o_a_rdata   (a_rdata),
        .i_b_req     (b_req),
        .i_b_we      (b_we),
        .i_b_addr    (b_addr),
        .i_b_wdata   (b_wdata),
        .o_b_ack     (b_ack),
        .o_b_rdata   (b_rdata),
        .o_ram_addr  (ram_addr),
        .o_ram_we    (ram_we),
        .o_ram_wdata (ram_wdata),
        .i_ram_rdata (ram_rdata),
        .o_busy      (busy)
    );

    // Behavioural RAM: synchronous write, registered read, and a preload port
    // for test setup. It is two-state, so it starts all-zero.
    bit   [DW-1:0] ram_mem [65536];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_en) ram_mem[pl_addr] <= pl_data;
        else if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    // ---------------- reference model ----------------
    bit   [DW-1:0] mem_m [65536];   // expected memory contents
    int            m_left  = 0;     // cycles until retirement; 3 = ISSUE, 1 = DONE
    bit            m_win   = 1'b0;  // 0 = A, 1 = B
    bit            m_last  = 1'b1;  // last completed grant; B after reset
    bit            m_write = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_a_rd  = '0;
    logic [DW-1:0] m_b_rd  = '0;

    // Advance the model across one rising edge, using the inputs as they are now.
    function automatic void model_step();
        if (pl_en) mem_m[pl_addr] = pl_data;
        if (m_left == 3 && m_write) mem_m[m_addr] = m_wdata;  // commits even under reset
        if (!rst_n) begin
            m_left = 0; m_win = 1'b0; m_last = 1'b1; m_write = 1'b0;
            m_addr = '0; m_wdata = '0; m_a_rd = '0; m_b_rd = '0;
        end else if (m_left == 0) begin
            if (a_req || b_req) begin
                m_win   = (a_req && b_req) ? ~m_last : b_req;
                m_left  = 3;
                m_write = m_win && b_we;
                m_addr  = m_win ? b_addr : a_addr;
                if (m_win) m_wdata = b_wdata;
            end
        end else begin
            m_left--;
            if (m_left == 1 && !m_write) begin
                if (m_win) m_b_rd = mem_m[m_addr];
                else       m_a_rd = mem_m[m_addr];
            end
            if (m_left == 0) m_last = m_win;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one clock edge, then compare every DUT output against the model.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("busy",      32'(busy),      32'(m_left > 0));
        check("a_ack",     32'(a_ack),     32'(m_left == 1 && !m_win));
        check("b_ack",     32'(b_ack),     32'(m_left == 1 && m_win));
        check("one_ack",   32'(a_ack & b_ack), 32'd0);
        check("ram_we",    32'(ram_we),    32'(m_left == 3 && m_write));
        check("ram_addr",  32'(ram_addr),  32'(m_addr));
        check("ram_wdata", ram_wdata,      m_wdata);
        check("a_rdata",   a_rdata,        m_a_rd);
        check("b_rdata",   b_rdata,        m_b_rd);
    endtask

    // Complete one access: hold the request through the ack cycle, then drop it.
    task automatic do_a(input logic [AW-1:0] addr);
        a_req = 1'b1; a_addr = addr;
        repeat (3) cycle();
        check("a_ack_at_n3", 32'(a_ack), 32'd1);
        a_req = 1'b0;
        cycle();
    endtask

    task automatic do_b(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
        repeat (3) cycle();
        check("b_ack_at_n3", 32'(b_ack), 32'd1);
        b_req = 1'b0;
        cycle();
    endtask

    bit            a_pend;
    bit            b_pend;
    logic [DW-1:0] saved;

    initial begin
        rst_n = 1'b0;
        a_req = 1'b0; a_addr = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;

        // Reset with preloads of two words.
        pl_en = 1'b1; pl_addr = 16'h0010; pl_data = 32'hDEADBEEF;
        cycle();
        pl_addr = 16'h0040; pl_data = 32'h5A5A0F0F;
        cycle();
        pl_en = 1'b0;
        cycle();
        rst_n = 1'b1;

        // A read of a preloaded word: address in N+1, busy N+1..N+3, data at ack.
        a_req = 1'b1; a_addr = 16'h0010;
        cycle();
        check("a_rd_addr_n1", 32'(ram_addr), 32'h0010);
        check("a_rd_busy_n1", 32'(busy), 32'd1);
        cycle();
        check("a_rd_busy_n2", 32'(busy), 32'd1);
        cycle();
        check("a_rd_ack_n3", 32'(a_ack), 32'd1);
        check("a_rd_data_n3", a_rdata, 32'hDEADBEEF);
        a_req = 1'b0;
        cycle();
        check("a_rd_idle_n4", 32'(busy), 32'd0);

        // B write, then B read of the same word.
        saved = b_rdata;
        do_b(1'b1, 16'h0020, 32'h12345678);
        check("b_wr_rdata_kept", b_rdata, saved);
        do_b(1'b0, 16'h0020, 32'h0);
        check("b_rd_back", b_rdata, 32'h12345678);

        // Continuous contention from reset: acks A@3, B@7, A@11.
        rst_n = 1'b0; a_req = 1'b1; a_addr = 16'h0010;
        b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0020;
        cycle();
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            check("cont_a_ack", 32'(a_ack), 32'(k == 3 || k == 11));
            check("cont_b_ack", 32'(b_ack), 32'(k == 7));
        end
        a_req = 1'b0; b_req = 1'b0;
        cycle();

        // A request while B's write strobe input is high: no RAM write happens.
        saved = b_rdata;
        b_we = 1'b1; b_wdata = 32'hFFFF0000; b_addr = 16'h0010;
        a_req = 1'b1; a_addr = 16'h0010;
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) a_req = 1'b0;
            cycle();
            check("a_only_no_we", 32'(ram_we), 32'd0);
        end
        check("a_only_a_rdata", a_rdata, 32'hDEADBEEF);
        check("a_only_b_rdata", b_rdata, saved);
        b_we = 1'b0;

        // Reset during WAIT of a B read: no ack, rdata cleared, then A works.
        do_b(1'b0, 16'h0020, 32'h0);
        b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0040;
        cycle();
        cycle();
        rst_n = 1'b0; b_req = 1'b0;
        cycle();
        check("rst_wait_busy", 32'(busy), 32'd0);
        check("rst_wait_ack", 32'(b_ack), 32'd0);
        check("rst_wait_rdata", b_rdata, 32'd0);
        rst_n = 1'b1;
        do_a(16'h0040);
        check("post_rst_a_rdata", a_rdata, 32'h5A5A0F0F);

        // Reset sampled at the end of ISSUE of a B write: the write still commits.
        b_req = 1'b1; b_we = 1'b1; b_addr = 16'h0030; b_wdata = 32'hA5A5A5A5;
        cycle();
        check("rst_issue_we", 32'(ram_we), 32'd1);
        rst_n = 1'b0; b_req = 1'b0; b_we = 1'b0;
        cycle();
        check("rst_issue_no_ack", 32'(b_ack), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("rst_issue_no_ack_later", 32'(b_ack), 32'd0);
        end
        do_b(1'b0, 16'h0030, 32'h0);
        check("rst_issue_committed", b_rdata, 32'hA5A5A5A5);

        // Randomized phase: independent requesters obeying the hold-until-ack rule,
        // with occasional resets.
        a_pend = 1'b0; b_pend = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                rst_n = 1'b0; a_req = 1'b0; b_req = 1'b0;
                a_pend = 1'b0; b_pend = 1'b0;
                cycle();
                rst_n = 1'b1;
            end else begin
                if (!a_pend && $urandom_range(0, 2) == 0) begin
                    a_pend = 1'b1;
                    a_addr = AW'($urandom_range(0, 63));
                end
                if (!b_pend && $urandom_range(0, 2) == 0) begin
                    b_pend  = 1'b1;
                    b_we    = 1'($urandom_range(0, 1));
                    b_addr  = AW'($urandom_range(0, 63));
                    b_wdata = $urandom;
                end
                a_req = a_pend; b_req = b_pend;
                cycle();
                if (a_ack) a_pend = 1'b0;
                if (b_ack) b_pend = 1'b0;
                if (!a_pend) a_req = 1'b0;
                if (!b_pend) b_req = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
